// File: rtl/alignment_traceback_if.sv
// ============================================================================
// Module   : alignment_traceback_if
// Brief    : Handshake, direction-memory and command-array bundle of the
//            alignment traceback stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alignment_traceback_if #(
  parameter int LEN = 7
) ();
  localparam int AW = $clog2((LEN + 1) * (LEN + 1));

  logic                    start;
  logic                    dir_rd_en;
  logic [AW-1:0]           dir_addr;
  logic [1:0]              dir_data;
  logic                    busy;
  logic                    done;
  logic                    cmd_valid;
  logic [0:3*LEN][0:2]     CommandsB;
  logic [0:3*LEN][0:2]     CommandsC;

  // master is the traceback engine, slave is its environment
  modport master (
    input  start, dir_data,
    output dir_rd_en, dir_addr, busy, done, cmd_valid, CommandsB, CommandsC
  );

  modport slave (
    output start, dir_data,
    input  dir_rd_en, dir_addr, busy, done, cmd_valid, CommandsB, CommandsC
  );
endinterface

`default_nettype wire

// File: rtl/alignment_traceback.sv
// ============================================================================
// Module   : alignment_traceback
// Brief    : Walks the Needleman-Wunsch direction matrix from (LEN,LEN) to
//            (0,0) and emits forward-ordered edit commands for B and C.
//            Optional macro TRACEBACK_STATS_EN adds step_count/gap_count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alignment_traceback #(
  parameter int LEN = 7,
  parameter int AW  = $clog2((LEN + 1) * (LEN + 1))
) (
  input  logic                           clk,
  input  logic                           reset,
  alignment_traceback_if.master          bus
`ifdef TRACEBACK_STATS_EN
  ,
  output logic [$clog2(2*LEN+1)-1:0]     step_count,
  output logic [$clog2(2*LEN+1)-1:0]     gap_count
`endif
);

  localparam int IW   = $clog2(LEN + 1);
  localparam int NW   = $clog2(2 * LEN + 1);
  localparam int KW   = $clog2(3 * LEN + 1);
  localparam int BW   = $clog2(2 * LEN);
  localparam int NCMD = 3 * LEN + 1;

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_ADDR   = 3'd1;
  localparam logic [2:0] c_DECODE = 3'd2;
  localparam logic [2:0] c_COPY   = 3'd3;
  localparam logic [2:0] c_DONE   = 3'd4;

  localparam logic [2:0] c_DELETE = 3'd0;
  localparam logic [2:0] c_INSERT = 3'd1;
  localparam logic [2:0] c_KEEP   = 3'd2;
  localparam logic [2:0] c_NOP    = 3'd3;

  logic [2:0]              r_state;
  logic [IW-1:0]           r_i;
  logic [IW-1:0]           r_j;
  logic [NW-1:0]           r_n;
  logic [KW-1:0]           r_k;
  logic [2:0]              r_buf_b [0:2*LEN-1];
  logic [2:0]              r_buf_c [0:2*LEN-1];
  logic [0:NCMD-1][0:2]    r_cmd_b;
  logic [0:NCMD-1][0:2]    r_cmd_c;
  logic                    r_cmd_valid;

  logic [1:0]              w_dir;
  logic [2:0]              w_cmd_b;
  logic [2:0]              w_cmd_c;
  logic [IW-1:0]           w_ni;
  logic [IW-1:0]           w_nj;
  logic                    w_k_lt_n;
  logic [BW-1:0]           w_ridx;

`ifdef TRACEBACK_STATS_EN
  logic [NW-1:0]           r_gap;
  logic                    w_gap;
`endif

  // Matrix edges force the walk along the border regardless of memory
  always_comb begin
    w_dir = bus.dir_data;
    if (r_i == '0) begin
      w_dir = 2'b11;
    end else if (r_j == '0) begin
      w_dir = 2'b10;
    end
    w_cmd_b = c_KEEP;
    w_cmd_c = c_KEEP;
    w_ni    = r_i;
    w_nj    = r_j;
`ifdef TRACEBACK_STATS_EN
    w_gap   = 1'b0;
`endif
    case (w_dir)
      2'b00: begin
        w_ni = r_i - IW'(1);
        w_nj = r_j - IW'(1);
      end
      2'b01: begin
        w_cmd_c = c_DELETE;
        w_ni    = r_i - IW'(1);
        w_nj    = r_j - IW'(1);
      end
      2'b10: begin
        w_cmd_c = c_INSERT;
        w_ni    = r_i - IW'(1);
`ifdef TRACEBACK_STATS_EN
        w_gap   = 1'b1;
`endif
      end
      default: begin
        w_cmd_b = c_INSERT;
        w_nj    = r_j - IW'(1);
`ifdef TRACEBACK_STATS_EN
        w_gap   = 1'b1;
`endif
      end
    endcase
  end

  // The reverse buffer holds steps last-to-first; COPY reads it backwards
  assign w_k_lt_n = (r_k < KW'(r_n));
  assign w_ridx   = BW'(KW'(r_n) - r_k - KW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_IDLE;
      r_i         <= '0;
      r_j         <= '0;
      r_n         <= '0;
      r_k         <= '0;
      r_cmd_b     <= {NCMD{c_NOP}};
      r_cmd_c     <= {NCMD{c_NOP}};
      r_cmd_valid <= 1'b0;
`ifdef TRACEBACK_STATS_EN
      r_gap       <= '0;
`endif
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.start) begin
            r_i         <= IW'(LEN);
            r_j         <= IW'(LEN);
            r_n         <= '0;
            r_cmd_valid <= 1'b0;
`ifdef TRACEBACK_STATS_EN
            r_gap       <= '0;
`endif
            r_state     <= c_ADDR;
          end
        end
        c_ADDR: begin
          r_state <= c_DECODE;
        end
        c_DECODE: begin
          r_buf_b[BW'(r_n)] <= w_cmd_b;
          r_buf_c[BW'(r_n)] <= w_cmd_c;
          r_n               <= r_n + NW'(1);
          r_i               <= w_ni;
          r_j               <= w_nj;
`ifdef TRACEBACK_STATS_EN
          if (w_gap) begin
            r_gap <= r_gap + NW'(1);
          end
`endif
          if ((w_ni == '0) && (w_nj == '0)) begin
            r_k     <= '0;
            r_state <= c_COPY;
          end else begin
            r_state <= c_ADDR;
          end
        end
        c_COPY: begin
          r_cmd_b[r_k] <= w_k_lt_n ? r_buf_b[w_ridx] : c_NOP;
          r_cmd_c[r_k] <= w_k_lt_n ? r_buf_c[w_ridx] : c_NOP;
          if (r_k == KW'(3 * LEN)) begin
            r_cmd_valid <= 1'b1;
            r_state     <= c_DONE;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign bus.dir_rd_en = (r_state == c_ADDR);
  assign bus.dir_addr  = (r_state == c_ADDR) ?
                         (AW'(r_i) * AW'(LEN + 1) + AW'(r_j)) : '0;
  assign bus.busy      = (r_state == c_ADDR) || (r_state == c_DECODE) ||
                         (r_state == c_COPY);
  assign bus.done      = (r_state == c_DONE);
  assign bus.cmd_valid = r_cmd_valid;
  assign bus.CommandsB = r_cmd_b;
  assign bus.CommandsC = r_cmd_c;

`ifdef TRACEBACK_STATS_EN
  assign step_count = r_n;
  assign gap_count  = r_gap;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alignment_traceback.sv
// ============================================================================
// Module   : tb_alignment_traceback
// Brief    : Randomized scoreboard bench for alignment_traceback against a
//            queue-based traceback reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alignment_traceback;

  localparam int LEN  = 7;
  localparam int NCMD = 3 * LEN + 1;
  localparam int SW   = $clog2(2 * LEN + 1);
  localparam int CELLS = (LEN + 1) * (LEN + 1);

  localparam logic [2:0] DEL  = 3'd0;
  localparam logic [2:0] INS  = 3'd1;
  localparam logic [2:0] KEEP = 3'd2;
  localparam logic [2:0] NOP  = 3'd3;

  typedef logic [0:NCMD-1][0:2] cmds_t;
  typedef struct {
    cmds_t b;
    cmds_t c;
    int    done_cyc;
    int    steps;
    int    gaps;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [1:0] dmem [0:CELLS-1];
  cmds_t      all_nop;

  alignment_traceback_if #(.LEN(LEN)) bus ();

`ifdef TRACEBACK_STATS_EN
  logic [SW-1:0] step_count;
  logic [SW-1:0] gap_count;
`endif

  alignment_traceback #(.LEN(LEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus)
`ifdef TRACEBACK_STATS_EN
    ,
    .step_count (step_count),
    .gap_count  (gap_count)
`endif
  );

  always #5 clk = ~clk;

  // Direction memory: registered read, data one cycle after the strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.dir_rd_en) bus.dir_data <= dmem[bus.dir_addr];
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the matrix, prepending each step so the list ends up forward
  function automatic exp_t model();
    exp_t       e;
    logic [2:0] fb[$];
    logic [2:0] fc[$];
    int         i;
    int         j;
    logic [1:0] d;
    i = LEN;
    j = LEN;
    e.gaps = 0;
    e.done_cyc = 0;
    while (i > 0 || j > 0) begin
      if (i == 0)      d = 2'd3;
      else if (j == 0) d = 2'd2;
      else             d = dmem[i * (LEN + 1) + j];
      case (d)
        2'd0: begin fb.push_front(KEEP); fc.push_front(KEEP); i--; j--; end
        2'd1: begin fb.push_front(KEEP); fc.push_front(DEL);  i--; j--; end
        2'd2: begin fb.push_front(KEEP); fc.push_front(INS);  i--; e.gaps++; end
        default: begin fb.push_front(INS); fc.push_front(KEEP); j--; e.gaps++; end
      endcase
    end
    e.steps = fb.size();
    for (int k = 0; k < NCMD; k++) begin
      if (k < fb.size()) begin
        e.b[k] = fb[k];
        e.c[k] = fc[k];
      end else begin
        e.b[k] = NOP;
        e.c[k] = NOP;
      end
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {127'd0, bus.done}, 128'd0);
      end else begin
        mon_e = sb.pop_front();
        check("CommandsB", bus.CommandsB, mon_e.b);
        check("CommandsC", bus.CommandsC, mon_e.c);
        check("done_cycle", cyc, mon_e.done_cyc);
        check("cmd_valid_at_done", bus.cmd_valid, 1);
`ifdef TRACEBACK_STATS_EN
        check("step_count", step_count, mon_e.steps);
        check("gap_count", gap_count, mon_e.gaps);
`endif
      end
    end
  end

  task automatic fill(input int mode);
    for (int a = 0; a < CELLS; a++) begin
      case (mode)
        0:       dmem[a] = 2'd0;
        default: dmem[a] = 2'($urandom_range(0, 3));
      endcase
    end
  endtask

  task automatic run(input bit mid_pulse, input bit done_pulse);
    exp_t e;
    int   t;
    e = model();
    @(negedge clk);
    e.done_cyc = cyc + 2 * e.steps + 3 * LEN + 2;
    sb.push_back(e);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("cmd_valid_cleared", bus.cmd_valid, 0);
    if (mid_pulse) begin
      repeat (4) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    t = 0;
    while (!bus.done && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!bus.done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done within %0d cycles", t);
      sb.delete();
    end else begin
      if (done_pulse) bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("cmd_valid_after_done", bus.cmd_valid, 1);
      check("rd_en_after_done", bus.dir_rd_en, 0);
      check("busy_after_done", bus.busy, 0);
      if (done_pulse) begin
        repeat (6) begin
          @(negedge clk);
          check("no_restart_rd_en", bus.dir_rd_en, 0);
          check("no_restart_valid", bus.cmd_valid, 1);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    all_nop = {NCMD{NOP}};
    bus.start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_cmd_valid", bus.cmd_valid, 0);
    check("rst_rd_en", bus.dir_rd_en, 0);
    check("rst_addr", bus.dir_addr, 0);
    check("rst_cmdB", bus.CommandsB, all_nop);
    check("rst_cmdC", bus.CommandsC, all_nop);

    // All-match diagonal
    fill(0);
    run(0, 0);

    // Mismatch at the starting cell
    dmem[LEN * (LEN + 1) + LEN] = 2'd1;
    run(0, 0);

    // Straight up column j=LEN then forced left along row 0
    fill(0);
    for (int i = 1; i <= LEN; i++) dmem[i * (LEN + 1) + LEN] = 2'd2;
    run(0, 0);

    // Reset during the third ADDR cycle
    fill(0);
    sb.push_back(model());
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("third_addr_rd_en", bus.dir_rd_en, 1);
    reset = 1'b1;
    @(negedge clk);
    sb.delete();
    check("midrst_busy", bus.busy, 0);
    check("midrst_cmd_valid", bus.cmd_valid, 0);
    check("midrst_rd_en", bus.dir_rd_en, 0);
    check("midrst_addr", bus.dir_addr, 0);
    check("midrst_cmdB", bus.CommandsB, all_nop);
    check("midrst_cmdC", bus.CommandsC, all_nop);
    reset = 1'b0;
    run(0, 0);

    // Start pulses while busy and on the done cycle are ignored
    fill(1);
    run(1, 1);

    for (int r = 0; r < 8; r++) begin
      fill(1);
      run(0, 0);
    end

    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover_expectations: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
